alt_vipitc121_is2vid_sync_apply: RTL and testbench

Applies the genlock correction issued by the IS2Vid sync comparator to the clocked-video-output timing counters. It owns the output frame's horizontal and vertical sample counters. At each end of frame it either shortens the next frame by jumping ahead (remove) or lengthens the current one by inserting blanking (repeat). It then holds off further corrections until the comparator's measurement has settled.

---
 rtl/alt_vipitc121_is2vid_sync_apply_pkg.sv | 13 +
 rtl/alt_vipitc121_is2vid_sync_apply_if.sv | 35 +++
 rtl/alt_vipitc121_is2vid_sync_apply_ext_counter.sv | 42 ++++
 rtl/alt_vipitc121_is2vid_sync_apply.sv | 132 +++++++++++++
 tb/tb_alt_vipitc121_is2vid_sync_apply.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alt_vipitc121_is2vid_sync_apply_pkg.sv
// Shared types and widths for the IS2Vid sync-apply block.
package alt_vipitc121_sync_apply_pkg;

  localparam int H_W = 14;
  localparam int V_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    EXTEND,
    HOLDOFF
  } state_e;

endpackage

// File: rtl/alt_vipitc121_is2vid_sync_apply_if.sv
// Timing, correction-request and counter-status bundle of the sync-apply block.
interface alt_vipitc121_is2vid_sync_apply_if;
  import alt_vipitc121_sync_apply_pkg::*;

  logic           enable;
  logic           restart;
  logic [H_W-1:0] h_total_minus_one;
  logic [V_W-1:0] v_total_minus_one;
  logic           sync_lines;
  logic           sync_samples;
  logic           remove_repeatn;
  logic [H_W-1:0] sync_compare_h_reset;
  logic [V_W-1:0] sync_compare_v_reset;
  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;
  logic           sof;
  logic           extending;
  logic           applied;
  logic           busy;

  modport master (
    output enable, restart, h_total_minus_one, v_total_minus_one,
           sync_lines, sync_samples, remove_repeatn,
           sync_compare_h_reset, sync_compare_v_reset,
    input  h_count, v_count, sof, extending, applied, busy
  );

  modport slave (
    input  enable, restart, h_total_minus_one, v_total_minus_one,
           sync_lines, sync_samples, remove_repeatn,
           sync_compare_h_reset, sync_compare_v_reset,
    output h_count, v_count, sof, extending, applied, busy
  );

endinterface

// File: rtl/alt_vipitc121_is2vid_sync_apply_ext_counter.sv
// Enabled 2-D sample/line counter that pulses done_o on the enabled cycle
// whose advance reaches the target position.
module alt_vipitc121_sync_apply_ext_counter
  import alt_vipitc121_sync_apply_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  logic           enable_i,
  input  logic [H_W-1:0] h_max_i,
  input  logic [H_W-1:0] target_h_i,
  input  logic [V_W-1:0] target_v_i,
  output logic           done_o
);

  logic [H_W-1:0] eh_q, eh_d, inc_h;
  logic [V_W-1:0] ev_q, ev_d, inc_v;

  always_comb begin
    inc_h = eh_q + 1'b1;
    inc_v = ev_q;
    if (eh_q >= h_max_i) begin
      inc_h = '0;
      inc_v = ev_q + 1'b1;
    end
    eh_d = enable_i ? inc_h : eh_q;
    ev_d = enable_i ? inc_v : ev_q;
  end

  assign done_o = enable_i && (inc_h == target_h_i) && (inc_v == target_v_i);

  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      eh_q <= '0;
      ev_q <= '0;
    end else begin
      eh_q <= eh_d;
      ev_q <= ev_d;
    end
  end

endmodule

// File: rtl/alt_vipitc121_is2vid_sync_apply.sv
// Applies genlock remove/repeat corrections to the CVO frame counters.
// Optional per-frame line-step clamp: ALT_VIPITC121_SYNC_APPLY_STEP_LIMIT_EN.
module alt_vipitc121_is2vid_sync_apply
  import alt_vipitc121_sync_apply_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 2,
  parameter int MAX_LINE_STEP  = 16
) (
  input logic clk,
  input logic rst,
  alt_vipitc121_is2vid_sync_apply_if.slave bus
);

  state_e         state_q, state_d;
  logic [H_W-1:0] h_q, h_d, tgt_h_q, tgt_h_d, hr;
  logic [V_W-1:0] v_q, v_d, tgt_v_q, tgt_v_d, vr;
  logic [3:0]     hold_q, hold_d;
  logic           applied_q, applied_d;
  logic           h_last, v_last, eof, ext_done;

  // >= so that shrinking the totals mid-frame truncates the line instead of running to overflow
  assign h_last = h_q >= bus.h_total_minus_one;
  assign v_last = v_q >= bus.v_total_minus_one;
  assign eof    = bus.enable && h_last && v_last;

  always_comb begin
    hr = '0;
    vr = '0;
    if (bus.sync_samples)
      hr = (bus.sync_compare_h_reset > bus.h_total_minus_one) ? bus.h_total_minus_one
                                                              : bus.sync_compare_h_reset;
    if (bus.sync_lines)
      vr = (bus.sync_compare_v_reset > bus.v_total_minus_one) ? bus.v_total_minus_one
                                                              : bus.sync_compare_v_reset;
`ifdef ALT_VIPITC121_SYNC_APPLY_STEP_LIMIT_EN
    // The sample residue is dropped; the comparator re-measures it in later frames
    if (vr > V_W'(MAX_LINE_STEP)) begin
      vr = V_W'(MAX_LINE_STEP);
      hr = '0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    tgt_h_d   = tgt_h_q;
    tgt_v_d   = tgt_v_q;
    hold_d    = hold_q;
    applied_d = 1'b0;

    if (bus.enable && state_q != EXTEND) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (eof && (hr != '0 || vr != '0)) begin
          applied_d = 1'b1;
          tgt_h_d   = hr;
          tgt_v_d   = vr;
          if (bus.remove_repeatn) begin
            h_d     = hr;
            v_d     = vr;
            state_d = HOLDOFF;
          end else begin
            state_d = EXTEND;
          end
        end
      end
      EXTEND: begin
        if (ext_done) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (eof) begin
          if (hold_q == 4'(HOLDOFF_FRAMES - 1)) begin
            hold_d  = '0;
            state_d = IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.restart) begin
      state_q   <= IDLE;
      h_q       <= '0;
      v_q       <= '0;
      tgt_h_q   <= '0;
      tgt_v_q   <= '0;
      hold_q    <= '0;
      applied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      tgt_h_q   <= tgt_h_d;
      tgt_v_q   <= tgt_v_d;
      hold_q    <= hold_d;
      applied_q <= applied_d;
    end
  end

  alt_vipitc121_sync_apply_ext_counter u_ext (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (bus.restart || state_q != EXTEND),
    .enable_i  (bus.enable && state_q == EXTEND),
    .h_max_i   (bus.h_total_minus_one),
    .target_h_i(tgt_h_q),
    .target_v_i(tgt_v_q),
    .done_o    (ext_done)
  );

  assign bus.h_count   = h_q;
  assign bus.v_count   = v_q;
  assign bus.sof       = (h_q == '0) && (v_q == '0) && (state_q != EXTEND);
  assign bus.extending = (state_q == EXTEND);
  assign bus.applied   = applied_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alt_vipitc121_is2vid_sync_apply.sv
// Self-checking bench for alt_vipitc121_is2vid_sync_apply: directed scenarios plus
// randomized traffic against a frame-position reference model.
module tb_alt_vipitc121_is2vid_sync_apply;
  import alt_vipitc121_sync_apply_pkg::*;

  localparam int HOLDOFF  = 2;
  localparam int MAX_STEP = 16;
  localparam int M_IDLE = 0, M_EXT = 1, M_HOLD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alt_vipitc121_is2vid_sync_apply_if bus();

  alt_vipitc121_is2vid_sync_apply #(
    .HOLDOFF_FRAMES(HOLDOFF),
    .MAX_LINE_STEP (MAX_STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int mH = 0, mV = 0, mMode = M_IDLE, mExtLeft = 0, mHoldLeft = 0;
  bit mApplied = 1'b0;

  wire [30:0] dutOuts = {bus.h_count, bus.v_count, bus.sof, bus.extending, bus.applied, bus.busy};

  function automatic logic [30:0] expOuts();
    logic sofE;
    sofE = (mH == 0) && (mV == 0) && (mMode != M_EXT);
    return {14'(mH), 13'(mV), sofE, (mMode == M_EXT), mApplied, (mMode != M_IDLE)};
  endfunction

  // Position is tracked as a linear sample index within the frame; extension as a countdown
  function automatic void modelStep();
    int hTot, vTot, pos, hr, vr;
    bit eof;
    hTot = int'(bus.h_total_minus_one) + 1;
    vTot = int'(bus.v_total_minus_one) + 1;
    mApplied = 1'b0;
    if (!rst || bus.restart) begin
      mH = 0; mV = 0; mMode = M_IDLE; mExtLeft = 0; mHoldLeft = 0;
      return;
    end
    if (!bus.enable) return;
    if (mMode == M_EXT) begin
      mExtLeft--;
      if (mExtLeft == 0) begin
        mMode = M_HOLD;
        mHoldLeft = HOLDOFF;
      end
      return;
    end
    eof = (mH == hTot - 1) && (mV == vTot - 1);
    pos = (mV * hTot + mH + 1) % (hTot * vTot);
    mH = pos % hTot;
    mV = pos / hTot;
    if (!eof) return;
    if (mMode == M_HOLD) begin
      mHoldLeft--;
      if (mHoldLeft == 0) mMode = M_IDLE;
      return;
    end
    hr = bus.sync_samples ? ((int'(bus.sync_compare_h_reset) < hTot) ? int'(bus.sync_compare_h_reset) : hTot - 1) : 0;
    vr = bus.sync_lines   ? ((int'(bus.sync_compare_v_reset) < vTot) ? int'(bus.sync_compare_v_reset) : vTot - 1) : 0;
`ifdef ALT_VIPITC121_SYNC_APPLY_STEP_LIMIT_EN
    if (vr > MAX_STEP) begin
      vr = MAX_STEP;
      hr = 0;
    end
`endif
    if (hr == 0 && vr == 0) return;
    mApplied = 1'b1;
    if (bus.remove_repeatn) begin
      mH = hr; mV = vr;
      mMode = M_HOLD;
      mHoldLeft = HOLDOFF;
    end else begin
      mMode = M_EXT;
      mExtLeft = vr * hTot + hr;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic clearReq();
    bus.sync_lines = 1'b0;
    bus.sync_samples = 1'b0;
    bus.remove_repeatn = 1'b0;
    bus.sync_compare_h_reset = '0;
    bus.sync_compare_v_reset = '0;
  endtask

  task automatic setReq(input bit remove, input int h, input int v);
    bus.sync_lines = 1'b1;
    bus.sync_samples = 1'b1;
    bus.remove_repeatn = remove;
    bus.sync_compare_h_reset = 14'(h);
    bus.sync_compare_v_reset = 13'(v);
  endtask

  task automatic doRestart();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
  endtask

  // Stops with the model showing the last sample of the frame, so the next edge is EOF
  task automatic runToEof();
    int n = 0;
    while (!(mH == int'(bus.h_total_minus_one) && mV == int'(bus.v_total_minus_one) && mMode != M_EXT) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      vectors++; miscompares++;
      $display("[TB] FAIL eof_wait: no end of frame within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    bus.h_total_minus_one = 14'd9;
    bus.v_total_minus_one = 13'd4;
    bus.enable = 1'b1;
    bus.restart = 1'b0;
    clearReq();
    rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if (dutOuts !== {14'd0, 13'd0, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h want %h", dutOuts, {14'd0, 13'd0, 4'b1000});
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (dutOuts !== expOuts()) begin
      miscompares++;
      $display("[TB] FAIL first_count: got %h want %h", dutOuts, expOuts());
    end
  endtask

  task automatic test_remove();
    runToEof();
    setReq(1'b1, 3, 2);
    tick();
    clearReq();
    vectors++;
    if (bus.h_count !== 14'd3 || bus.v_count !== 13'd2 || bus.applied !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL remove_load: got h=%0d v=%0d applied=%b busy=%b want 3 2 1 1",
               bus.h_count, bus.v_count, bus.applied, bus.busy);
    end
    for (int i = 1; i <= 26; i++) begin
      tick();
      vectors++;
      if (dutOuts !== expOuts()) begin
        miscompares++;
        $display("[TB] FAIL remove_run cyc %0d: got %h want %h", i, dutOuts, expOuts());
      end
    end
    vectors++;
    if (bus.h_count !== 14'd9 || bus.v_count !== 13'd4) begin
      miscompares++;
      $display("[TB] FAIL remove_next_eof: got h=%0d v=%0d want 9 4", bus.h_count, bus.v_count);
    end
  endtask

  task automatic test_repeat();
    int n;
    doRestart();
    runToEof();
    setReq(1'b0, 4, 1);
    tick();
    clearReq();
    vectors++;
    if (dutOuts !== {14'd0, 13'd0, 4'b0111}) begin
      miscompares++;
      $display("[TB] FAIL repeat_enter: got %h want %h", dutOuts, {14'd0, 13'd0, 4'b0111});
    end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++;
      if (dutOuts !== expOuts()) begin
        miscompares++;
        $display("[TB] FAIL repeat_run cyc %0d: got %h want %h", i, dutOuts, expOuts());
      end
      if (bus.extending !== 1'b1) break;
      n++;
    end
    vectors++;
    if (n != 14 || bus.sof !== 1'b1 || bus.h_count !== 14'd0 || bus.v_count !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL repeat_length: got %0d cycles sof=%b want 14 cycles sof=1", n, bus.sof);
    end
    tick();
    vectors++;
    if (bus.h_count !== 14'd1 || bus.v_count !== 13'd0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL repeat_resume: got h=%0d v=%0d busy=%b want 1 0 1", bus.h_count, bus.v_count, bus.busy);
    end
  endtask

  task automatic test_holdoff();
    int pulses[$];
    doRestart();
    setReq(1'b1, 3, 2);
    for (int i = 1; i <= 200; i++) begin
      tick();
      vectors++;
      if (dutOuts !== expOuts()) begin
        miscompares++;
        $display("[TB] FAIL holdoff_run cyc %0d: got %h want %h", i, dutOuts, expOuts());
      end
      if (bus.applied === 1'b1) pulses.push_back(i);
    end
    clearReq();
    vectors++;
    if (pulses.size() != 2 || pulses[0] != 50 || pulses[1] != 177) begin
      miscompares++;
      $display("[TB] FAIL holdoff_pulses: got %0d pulses (first %0d) want 2 at cycles 50 and 177",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
  endtask

  task automatic test_step_limit();
    bus.v_total_minus_one = 13'd99;
    doRestart();
    runToEof();
    setReq(1'b1, 5, 40);
    tick();
    clearReq();
`ifdef ALT_VIPITC121_SYNC_APPLY_STEP_LIMIT_EN
    vectors++;
    if (bus.v_count !== 13'd16 || bus.h_count !== 14'd0 || bus.applied !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL step_limit: got h=%0d v=%0d want 0 16", bus.h_count, bus.v_count);
    end
`else
    vectors++;
    if (bus.v_count !== 13'd40 || bus.h_count !== 14'd5 || bus.applied !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL step_limit: got h=%0d v=%0d want 5 40", bus.h_count, bus.v_count);
    end
`endif
    vectors++;
    if (dutOuts !== expOuts()) begin
      miscompares++;
      $display("[TB] FAIL step_limit_model: got %h want %h", dutOuts, expOuts());
    end
    bus.v_total_minus_one = 13'd4;
    doRestart();
  endtask

  task automatic test_restart();
    doRestart();
    runToEof();
    setReq(1'b0, 4, 1);
    tick();
    clearReq();
    repeat (4) tick();
    vectors++;
    if (bus.extending !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart_pre: got extending=%b want 1", bus.extending);
    end
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    vectors++;
    if (dutOuts !== {14'd0, 13'd0, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL restart_ext: got %h want %h", dutOuts, {14'd0, 13'd0, 4'b1000});
    end
    tick();
    vectors++;
    if (dutOuts !== expOuts()) begin
      miscompares++;
      $display("[TB] FAIL restart_resume: got %h want %h", dutOuts, expOuts());
    end
  endtask

  task automatic test_random();
    int hMax, vMax;
    for (int seg = 0; seg < 3; seg++) begin
      hMax = $urandom_range(2, 12);
      vMax = (seg == 2) ? 40 : $urandom_range(1, 6);
      bus.h_total_minus_one = 14'(hMax);
      bus.v_total_minus_one = 13'(vMax);
      clearReq();
      doRestart();
      for (int i = 0; i < 700; i++) begin
        bus.enable = ($urandom_range(0, 3) != 0);
        bus.sync_lines = 1'($urandom_range(0, 1));
        bus.sync_samples = 1'($urandom_range(0, 1));
        bus.remove_repeatn = 1'($urandom_range(0, 1));
        bus.sync_compare_h_reset = 14'($urandom_range(0, hMax + 2));
        bus.sync_compare_v_reset = 13'($urandom_range(0, vMax + 2));
        bus.restart = ($urandom_range(0, 299) == 0);
        tick();
        vectors++;
        if (dutOuts !== expOuts()) begin
          miscompares++;
          $display("[TB] FAIL random seg %0d cyc %0d: got %h want %h", seg, i, dutOuts, expOuts());
        end
      end
    end
    bus.restart = 1'b0;
    bus.enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_remove();
    test_repeat();
    test_holdoff();
    test_step_limit();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
